// File: rtl/div_share_arbiter.sv
// Round-robin arbiter that shares one sequential Run/Rdy divider among N_REQ clients.
// Divide-by-zero is answered locally; a watchdog aborts a divider that never answers.
module div_share_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 40
) (
  input  logic                   clk,
  input  logic                   Rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] dvnd_in,
  input  logic [N_REQ*WIDTH-1:0] dvsr_in,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic [WIDTH-1:0]       q_out,
  output logic [WIDTH-1:0]       r_out,
  output logic                   dz_err,
  output logic                   to_err,
  output logic                   div_run,
  output logic [WIDTH-1:0]       div_dvnd,
  output logic [WIDTH-1:0]       div_dvsr,
  input  logic                   div_rdy,
  input  logic [WIDTH-1:0]       div_q,
  input  logic [WIDTH-1:0]       div_r
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_RUN, S_WAIT, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    win_q, win_d, ptr_q, ptr_d, arb_idx;
  logic             arb_found;
  logic [WW-1:0]    wd_q, wd_d;
  logic [N_REQ-1:0] gnt_q, gnt_d, done_q, done_d;
  logic [WIDTH-1:0] q_q, q_d, r_q, r_d, dvnd_q, dvnd_d, dvsr_q, dvsr_d;
  logic             dz_q, dz_d, to_q, to_d, run_q, run_d;

  logic [WIDTH-1:0] dvnd_arr [N_REQ];
  logic [WIDTH-1:0] dvsr_arr [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign dvnd_arr[gi] = dvnd_in[gi*WIDTH +: WIDTH];
      assign dvsr_arr[gi] = dvsr_in[gi*WIDTH +: WIDTH];
    end
  endgenerate

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int step);
    int sum;
    sum = int'(base) + step;
    if (sum >= N_REQ) sum = sum - N_REQ;
    return PW'(sum);
  endfunction

  function automatic logic [N_REQ-1:0] one_hot(input logic [PW-1:0] idx);
    return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // First set request at or after the round-robin pointer wins.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!arb_found && req[wrap_add(ptr_q, k)]) begin
        arb_found = 1'b1;
        arb_idx   = wrap_add(ptr_q, k);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    wd_d    = wd_q;
    gnt_d   = '0;
    done_d  = '0;
    q_d     = '0;
    r_d     = '0;
    dz_d    = 1'b0;
    to_d    = 1'b0;
    run_d   = 1'b0;
    dvnd_d  = dvnd_q;
    dvsr_d  = dvsr_q;
    case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          state_d = S_GRANT;
          win_d   = arb_idx;
          gnt_d   = one_hot(arb_idx);
          dvnd_d  = dvnd_arr[arb_idx];
          dvsr_d  = dvsr_arr[arb_idx];
        end
      end
      S_GRANT: begin
        if (dvsr_q == '0) begin
          state_d = S_DONE;
          done_d  = one_hot(win_q);
          dz_d    = 1'b1;
          q_d     = '1;
          r_d     = dvnd_q;
        end else begin
          state_d = S_RUN;
          run_d   = 1'b1;
          wd_d    = '0;
        end
      end
      S_RUN: begin
        state_d = S_WAIT;
        wd_d    = '0;
      end
      S_WAIT: begin
        // wd_q == 0 marks the first WAIT cycle, where Rdy may still be left over from the last job.
        if (wd_q != '0 && div_rdy) begin
          state_d = S_DONE;
          done_d  = one_hot(win_q);
          q_d     = div_q;
          r_d     = div_r;
        end else if (wd_q == WD_LAST) begin
          state_d = S_DONE;
          done_d  = one_hot(win_q);
          to_d    = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        ptr_d   = wrap_add(win_q, 1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      ptr_q   <= '0;
      wd_q    <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
      to_q    <= 1'b0;
      run_q   <= 1'b0;
      dvnd_q  <= '0;
      dvsr_q  <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
      to_q    <= to_d;
      run_q   <= run_d;
      dvnd_q  <= dvnd_d;
      dvsr_q  <= dvsr_d;
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign q_out    = q_q;
  assign r_out    = r_q;
  assign dz_err   = dz_q;
  assign to_err   = to_q;
  assign div_run  = run_q;
  assign div_dvnd = dvnd_q;
  assign div_dvsr = dvsr_q;

endmodule
